// File: rtl/sm83_pkg.sv
// Shared SM83 peripheral types: bus widths, timer FSM states, TAC layout and
// register offsets within the timer block.
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  // Timer overflow handling: RUN counts normally, OVF holds TIMA at 00 for a
  // few cycles, RELOAD copies TMA into TIMA and raises the interrupt.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } timer_state_t;

  // TAC register: enable in bit 2, input clock select in bits 1:0.
  typedef struct packed {
    logic       en;
    logic [1:0] clk_sel;
  } tac_t;

  // Register offsets relative to the DIV address.
  localparam logic [1:0] TMR_DIV  = 2'd0;
  localparam logic [1:0] TMR_TIMA = 2'd1;
  localparam logic [1:0] TMR_TMA  = 2'd2;
  localparam logic [1:0] TMR_TAC  = 2'd3;

  // Cycles spent in OVF before the reload cycle.
  localparam logic [1:0] OVF_DELAY = 2'd3;

endpackage

// File: rtl/gb_timer.sv
// Game Boy style timer: free-running 16-bit divider, TIMA counting on falling
// edges of a selected divider tap, delayed TMA reload with interrupt pulse.
module gb_timer
  import sm83_pkg::*;
#(
  parameter addr_t BASE_ADDR = 16'hFF04
) (
  input  logic  clk,
  input  logic  rst,
  input  addr_t addr,
  input  data_t wdata,
  input  logic  wr_en,
  input  logic  rd_en,
  output data_t rdata,
  output logic  rd_valid,
  output logic  irq_req
);

  logic [15:0]  sys_cnt_reg, sys_cnt_next;
  data_t        tima_reg, tima_next;
  data_t        tma_reg, tma_next;
  tac_t         tac_reg, tac_next;
  timer_state_t state_reg, state_next;
  logic [1:0]   delay_reg, delay_next;
  logic         irq_reg, irq_next;
  data_t        rdata_reg;
  logic         rd_valid_reg;

  addr_t        offs;
  logic         hit;
  logic [1:0]   sel;
  logic         wr_div, wr_tima, wr_tma, wr_tac;
  logic         tick_fall;
  data_t        rd_mux;

  // Timer input: selected divider bit gated by the enable.
  function automatic logic tick_of(input logic [15:0] cnt, input tac_t tac);
    logic tap;
    case (tac.clk_sel)
      2'b00:   tap = cnt[9];
      2'b01:   tap = cnt[3];
      2'b10:   tap = cnt[5];
      default: tap = cnt[7];
    endcase
    return tap & tac.en;
  endfunction

  assign offs    = addr - BASE_ADDR;
  assign hit     = (offs[15:2] == 14'd0);
  assign sel     = offs[1:0];
  assign wr_div  = wr_en & hit & (sel == TMR_DIV);
  assign wr_tima = wr_en & hit & (sel == TMR_TIMA);
  assign wr_tma  = wr_en & hit & (sel == TMR_TMA);
  assign wr_tac  = wr_en & hit & (sel == TMR_TAC);

  // Next-state logic: divider, register writes, edge detect and overflow FSM.
  // The edge is taken between the current and next tick, so DIV and TAC
  // writes that drop the tick also count.
  always_comb begin
    sys_cnt_next = sys_cnt_reg + 16'd1;
    tac_next     = tac_reg;
    tma_next     = tma_reg;
    tima_next    = tima_reg;
    state_next   = state_reg;
    delay_next   = delay_reg;
    irq_next     = 1'b0;

    if (wr_div) sys_cnt_next = 16'd0;
    if (wr_tac) tac_next = tac_t'(wdata[2:0]);
    if (wr_tma) tma_next = wdata;

    tick_fall = tick_of(sys_cnt_reg, tac_reg) & ~tick_of(sys_cnt_next, tac_next);

    case (state_reg)
      RUN: begin
        if (wr_tima) begin
          tima_next = wdata;
        end else if (tick_fall) begin
          if (tima_reg == 8'hFF) begin
            tima_next  = 8'h00;
            state_next = OVF;
            delay_next = OVF_DELAY;
          end else begin
            tima_next = tima_reg + 8'd1;
          end
        end
      end
      OVF: begin
        delay_next = delay_reg - 2'd1;
        if (delay_reg <= 2'd1) begin
          delay_next = 2'd0;
          state_next = RELOAD;
        end
        // A CPU write to TIMA here cancels the pending reload and interrupt.
        if (wr_tima) begin
          tima_next  = wdata;
          state_next = RUN;
          delay_next = 2'd0;
        end else if (tick_fall) begin
          tima_next = tima_reg + 8'd1;
        end
      end
      RELOAD: begin
        // TMA (or a TMA write landing this cycle) overrides any TIMA write.
        tima_next  = wr_tma ? wdata : tma_reg;
        irq_next   = 1'b1;
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
        delay_next = 2'd0;
      end
    endcase
  end

  // Read mux over pre-write register values.
  always_comb begin
    case (sel)
      TMR_DIV:  rd_mux = sys_cnt_reg[15:8];
      TMR_TIMA: rd_mux = tima_reg;
      TMR_TMA:  rd_mux = tma_reg;
      default:  rd_mux = {5'b11111, tac_reg};
    endcase
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sys_cnt_reg <= 16'd0;
      tima_reg    <= 8'h00;
      tma_reg     <= 8'h00;
      tac_reg     <= '0;
      state_reg   <= RUN;
      delay_reg   <= 2'd0;
      irq_reg     <= 1'b0;
    end else begin
      sys_cnt_reg <= sys_cnt_next;
      tima_reg    <= tima_next;
      tma_reg     <= tma_next;
      tac_reg     <= tac_next;
      state_reg   <= state_next;
      delay_reg   <= delay_next;
      irq_reg     <= irq_next;
    end
  end

  // Registered read port: data appears the cycle after rd_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rdata_reg    <= 8'h00;
    end else begin
      rd_valid_reg <= rd_en & hit;
      rdata_reg    <= (rd_en & hit) ? rd_mux : 8'h00;
    end
  end

  assign rdata    = rdata_reg;
  assign rd_valid = rd_valid_reg;
  assign irq_req  = irq_reg;

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer: stimulus drives a behavioural model that
// queues expected read data and interrupt cycles; a monitor compares.
module tb_gb_timer;

  localparam logic [15:0] BASE = 16'hFF04;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  rdata;
  logic        rd_valid;
  logic        irq_req;

  gb_timer #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .irq_req  (irq_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cycle;
    bit valid;
    int data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      irq_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  // Reference model state: plain integers.
  // m_pend counts edges until the TMA reload lands (0 = none pending).
  int m_cnt, m_tima, m_tma, m_tac, m_pend;
  int tap_idx[4] = '{9, 3, 5, 7};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit tick(input int c, input int tc);
    return (((tc >> 2) & 1) == 1) && (((c >> tap_idx[tc & 3]) & 1) == 1);
  endfunction

  task automatic model_step(input bit r, input bit w, input bit rd,
                            input int a, input int d, input int t);
    int off, new_cnt, new_tac, old_pend;
    bit hit, fall;
    rd_exp_t e;
    if (r) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pend = 0;
      return;
    end
    off = a - BASE;
    hit = (off >= 0) && (off <= 3);
    if (rd) begin
      e.cycle = t;
      e.valid = hit;
      if (!hit)          e.data = 0;
      else if (off == 0) e.data = (m_cnt >> 8) & 255;
      else if (off == 1) e.data = m_tima;
      else if (off == 2) e.data = m_tma;
      else               e.data = 248 | m_tac;
      rd_q.push_back(e);
    end
    if (!(w && hit)) off = -1;
    new_cnt  = (off == 0) ? 0 : (m_cnt + 1) % 65536;
    new_tac  = (off == 3) ? (d & 7) : m_tac;
    fall     = tick(m_cnt, m_tac) && !tick(new_cnt, new_tac);
    old_pend = m_pend;
    if (old_pend == 1) begin
      m_tima = (off == 2) ? d : m_tma;
      m_pend = 0;
      irq_q.push_back(t);
    end else begin
      m_pend = (old_pend > 1) ? old_pend - 1 : 0;
      if (off == 1) begin
        m_tima = d;
        m_pend = 0;
      end else if (fall) begin
        if (m_tima == 255 && old_pend == 0) begin
          m_tima = 0;
          m_pend = 4;
        end else begin
          m_tima = (m_tima + 1) % 256;
        end
      end
    end
    if (off == 2) m_tma = d;
    m_cnt = new_cnt;
    m_tac = new_tac;
  endtask

  task automatic do_cycle(input bit r, input bit w, input bit rd,
                          input logic [15:0] a, input logic [7:0] d);
    rst   = r;
    wr_en = w;
    rd_en = rd;
    addr  = a;
    wdata = d;
    model_step(r, w, rd, int'(a), int'(d), cyc + 1);
    @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    do_cycle(1'b0, 1'b1, 1'b0, BASE + 16'(off), d);
  endtask

  task automatic rd(input int off);
    do_cycle(1'b0, 1'b0, 1'b1, BASE + 16'(off), 8'h00);
  endtask

  // Read TIMA every cycle until the model reaches the requested pending count.
  task automatic wait_pend(input int target);
    for (int i = 0; i < 400 && m_pend != target; i++) rd(1);
    n_checks++;
    if (m_pend != target) begin
      n_fail++;
      $display("FAIL wait_pend: timeout, pend=%0d, required %0d", m_pend, target);
    end
  endtask

  task automatic arm_overflow();
    wr(1, 8'hFE);
    wr(3, 8'h05);
  endtask

  // Monitor: compare every cycle against the queued expectations.
  always @(negedge clk) begin
    bit      exp_irq;
    rd_exp_t e;
    exp_irq = 1'b0;
    if (irq_q.size() > 0 && irq_q[0] == cyc) begin
      exp_irq = 1'b1;
      void'(irq_q.pop_front());
    end
    check("irq_req", 32'(irq_req), 32'(exp_irq));
    if (rd_q.size() > 0 && rd_q[0].cycle == cyc) begin
      e = rd_q.pop_front();
      check("rd_valid", 32'(rd_valid), 32'(e.valid));
      check("rdata", 32'(rdata), 32'(e.data));
    end else begin
      check("idle_rd_valid", 32'(rd_valid), 32'd0);
      check("idle_rdata", 32'(rdata), 32'd0);
    end
  end

  initial begin
    bit          r, w, rr;
    int          k, off;
    logic [7:0]  d;

    // Reset, then read every register: all zero, TAC reads F8.
    do_cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00);
    do_cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00);
    for (int i = 0; i < 4; i++) rd(i);

    // TAC=101, TIMA=FE, TMA=40 from a freshly cleared divider.
    wr(0, 8'h00);
    wr(1, 8'hFE);
    wr(2, 8'h40);
    wr(3, 8'h05);
    for (int i = 0; i < 40; i++) rd(1);
    rd(2);

    // Overflow, then TIMA write 77 mid-OVF: no reload, no interrupt.
    arm_overflow();
    wait_pend(2);
    wr(1, 8'h77);
    for (int i = 0; i < 8; i++) rd(1);

    // TMA write 99 in the reload cycle: both take 99, interrupt still fires.
    arm_overflow();
    wait_pend(1);
    wr(2, 8'h99);
    rd(1);
    rd(2);

    // TAC=100 with sys_cnt=0200: DIV write drops bit 9 and bumps TIMA.
    wr(1, 8'h10);
    wr(0, 8'h00);
    wr(3, 8'h04);
    for (int i = 0; i < 510; i++) do_cycle(1'b0, 1'b0, 1'b0, BASE, 8'h00);
    rd(0);
    wr(0, 8'h5A);
    rd(1);
    rd(0);

    // TAC readback with upper bits forced; out-of-range read.
    wr(3, 8'hFA);
    rd(3);
    do_cycle(1'b0, 1'b0, 1'b1, 16'hFF08, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b1, 16'hFF08, 8'h33);

    // Simultaneous read and write of TIMA returns the old value.
    wr(1, 8'h21);
    do_cycle(1'b0, 1'b1, 1'b1, BASE + 16'd1, 8'h42);
    rd(1);

    // Reset during OVF: everything zero and no interrupt for 10 cycles.
    arm_overflow();
    wait_pend(3);
    do_cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00);
    for (int i = 0; i < 10; i++) rd(i % 4);

    // Randomized traffic around the block's address window.
    for (int i = 0; i < 3000; i++) begin
      k   = $urandom_range(0, 99);
      off = $urandom_range(0, 5) - 1;
      d   = 8'($urandom_range(0, 255));
      r   = (k == 0);
      w   = (k >= 1 && k < 35);
      rr  = (k >= 25 && k < 80);
      if (w && off == 0 && $urandom_range(0, 3) != 0) w = 1'b0;
      if (w && off == 1 && $urandom_range(0, 1) == 1) d = d | 8'hF0;
      if (w && off == 3 && $urandom_range(0, 3) != 0) d = d | 8'h04;
      do_cycle(r, w, rr, BASE + 16'(off), d);
    end

    // Drain outstanding expectations.
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b0, 1'b0, BASE, 8'h00);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("irq_queue_drained", 32'(irq_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
